nested_fsm_ctrl: RTL

Parametrised hierarchical state-machine controller: a top-level colour FSM (BLUE, RED, HSV), where HSV is a composite state with its own child FSM (H, S, V). The child FSM auto-advances on a dwell timer and can optionally resume its last child on re-entry. Commands arrive over a valid/ready handshake, and outputs are registered. It replaces single-level Moore colour FSMs wherever mode sequencing with timed sub-phases is needed.

---
 rtl/nested_fsm_pkg.sv | 48 ++++
 rtl/dwell_timer.sv | 38 +++
 rtl/nested_fsm_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nested_fsm_pkg.sv
// Shared types and codes for the hierarchical colour controller.
//   top_state_t   : top-level FSM states (BLUE, RED, HSV)
//   child_state_t : HSV sub-phase states (H, S, V)
//   CMD_*         : command codes carried on cmd
//   OUT_*         : output codes driven on out
//   ST_*          : state_o encoding; bit 2 marks "inside HSV"
package nested_fsm_pkg;

  typedef enum logic [1:0] {
    BLUE = 2'd0,
    RED  = 2'd1,
    HSV  = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    H = 2'd0,
    S = 2'd1,
    V = 2'd2
  } child_state_t;

  localparam int unsigned CMD_HOLD   = 0;
  localparam int unsigned CMD_TOGGLE = 1;
  localparam int unsigned CMD_ENTER  = 2;
  localparam int unsigned CMD_EXIT   = 3;

  localparam int unsigned OUT_BLUE = 1;
  localparam int unsigned OUT_RED  = 2;
  localparam int unsigned OUT_H    = 2;
  localparam int unsigned OUT_S    = 3;
  localparam int unsigned OUT_V    = 0;

  localparam int unsigned STATE_O_W = 3;
  localparam logic [STATE_O_W-1:0] ST_BLUE = 3'd0;
  localparam logic [STATE_O_W-1:0] ST_RED  = 3'd1;
  localparam logic [STATE_O_W-1:0] ST_H    = 3'd4;
  localparam logic [STATE_O_W-1:0] ST_S    = 3'd5;
  localparam logic [STATE_O_W-1:0] ST_V    = 3'd6;

  // Child sequence H -> S -> V -> H.
  function automatic child_state_t next_child(input child_state_t c);
    case (c)
      H:       return S;
      S:       return V;
      default: return H;
    endcase
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the HSV sub-phases.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count at 0 (HSV entry)
//   en         : count this cycle (controller is inside HSV)
//   expire     : current cycle is the last of a DWELL-cycle dwell
module dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(DWELL + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..DWELL-1 and wrap, so the count never exceeds DWELL-1.
  always_comb begin
    cnt_d  = cnt_q;
    expire = en && (cnt_q == CNT_W'(DWELL - 1));
    if (clr) begin
      cnt_d = '0;
    end else if (expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nested_fsm_ctrl.sv
// Hierarchical colour controller: top FSM (BLUE/RED/HSV) with a timed
// H/S/V child FSM inside HSV and optional history on re-entry.
//   clk, rst_n : clock, async active-low reset
//   cmd_valid  : command present
//   cmd        : 0 HOLD, 1 TOGGLE, 2 ENTER, 3 EXIT; other codes ignored
//   cmd_ready  : command accepted this cycle when high
//   out        : registered output code
//   state_o    : registered state code (BLUE 0, RED 1, H 4, S 5, V 6)
//   cycle_done : one-cycle pulse after the V->H wrap
module nested_fsm_ctrl
  import nested_fsm_pkg::*;
#(
  parameter int unsigned CMD_W   = 2,
  parameter int unsigned OUT_W   = 2,
  parameter int unsigned DWELL   = 4,
  parameter int unsigned HISTORY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [CMD_W-1:0]     cmd,
  output logic                 cmd_ready,
  output logic [OUT_W-1:0]     out,
  output logic [STATE_O_W-1:0] state_o,
  output logic                 cycle_done
);

  top_state_t             top_q, top_d;
  child_state_t           child_q, child_d;
  child_state_t           hist_q, hist_d;
  logic [OUT_W-1:0]       out_q, out_d;
  logic [STATE_O_W-1:0]   state_o_q, state_o_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   cycle_done_q, cycle_done_d;

  logic accept, is_toggle, is_enter, is_exit;
  logic in_hsv, enter_acc, expire;

  assign accept    = cmd_valid && cmd_ready_q;
  assign is_toggle = accept && (cmd == CMD_W'(CMD_TOGGLE));
  assign is_enter  = accept && (cmd == CMD_W'(CMD_ENTER));
  assign is_exit   = accept && (cmd == CMD_W'(CMD_EXIT));
  assign in_hsv    = (top_q == HSV);
  assign enter_acc = is_enter && (top_q == RED);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (enter_acc),
    .en     (in_hsv),
    .expire (expire)
  );

  // Next-state for both FSM levels; EXIT takes priority over a dwell expiry.
  always_comb begin
    top_d        = top_q;
    child_d      = child_q;
    hist_d       = hist_q;
    cycle_done_d = 1'b0;
    case (top_q)
      BLUE: begin
        if (is_toggle) top_d = RED;
      end
      RED: begin
        if (is_toggle) begin
          top_d = BLUE;
        end else if (is_enter) begin
          top_d   = HSV;
          child_d = (HISTORY != 0) ? hist_q : H;
        end
      end
      HSV: begin
        if (is_exit) begin
          top_d  = RED;
          hist_d = child_q;
        end else if (expire) begin
          child_d      = next_child(child_q);
          cycle_done_d = (child_q == V);
        end
      end
      default: top_d = RED;
    endcase
    cmd_ready_d = (top_d == top_q);
  end

  // Outputs are registered from next-state, one cycle behind the command.
  always_comb begin
    state_o_d = ST_RED;
    out_d     = OUT_W'(OUT_RED);
    case (top_d)
      BLUE: begin
        state_o_d = ST_BLUE;
        out_d     = OUT_W'(OUT_BLUE);
      end
      HSV: begin
        case (child_d)
          H: begin
            state_o_d = ST_H;
            out_d     = OUT_W'(OUT_H);
          end
          S: begin
            state_o_d = ST_S;
            out_d     = OUT_W'(OUT_S);
          end
          default: begin
            state_o_d = ST_V;
            out_d     = OUT_W'(OUT_V);
          end
        endcase
      end
      default: begin
        state_o_d = ST_RED;
        out_d     = OUT_W'(OUT_RED);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q        <= RED;
      child_q      <= H;
      hist_q       <= H;
      out_q        <= OUT_W'(OUT_RED);
      state_o_q    <= ST_RED;
      cmd_ready_q  <= 1'b1;
      cycle_done_q <= 1'b0;
    end else begin
      top_q        <= top_d;
      child_q      <= child_d;
      hist_q       <= hist_d;
      out_q        <= out_d;
      state_o_q    <= state_o_d;
      cmd_ready_q  <= cmd_ready_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign out        = out_q;
  assign state_o    = state_o_q;
  assign cycle_done = cycle_done_q;

endmodule
